// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a zero-latency grant, a registered last-granted pointer
// and a saturating statistics counter of grant cycles.
module rr_arbiter #(
    parameter int unsigned N    = 10,
    parameter int unsigned logN = $clog2(N),
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            stall,
    output logic [N-1:0]    gnt,
    output logic            gnt_vld,
    output logic [logN-1:0] gnt_idx,
    output logic [logN-1:0] last_idx,
    output logic [CNTW-1:0] gnt_cnt
);

    // One extra bit so last_idx + offset (up to 2N-1) never overflows before the mod-N fold.
    localparam logic [logN:0]   L_N     = (logN + 1)'(N);
    localparam logic [logN-1:0] L_LAST  = logN'(N - 1);

    logic [logN-1:0] r_last;
    logic [CNTW-1:0] r_cnt;

    logic [N-1:0]    w_gnt;
    logic [logN-1:0] w_idx;
    logic            w_found;
    logic [logN:0]   w_pos;

    // Scan requesters in circular order starting just after the last grant; first hit wins.
    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        if (!rst && !stall) begin
            for (int unsigned k = 1; k <= N; k++) begin
                w_pos = {1'b0, r_last} + (logN + 1)'(k);
                if (w_pos >= L_N) begin
                    w_pos = w_pos - L_N;
                end
                if (!w_found && req[w_pos[logN-1:0]]) begin
                    w_found                 = 1'b1;
                    w_idx                   = w_pos[logN-1:0];
                    w_gnt[w_pos[logN-1:0]]  = 1'b1;
                end
            end
        end
    end

    // Pointer follows each grant; counter counts grant cycles and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= L_LAST;
            r_cnt  <= '0;
        end else if (w_found) begin
            r_last <= w_idx;
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign gnt      = w_gnt;
    assign gnt_vld  = w_found;
    assign gnt_idx  = w_idx;
    assign last_idx = r_last;
    assign gnt_cnt  = r_cnt;

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 10, number of requesters (N >= 2).
REQ-002 Parameter logN, default $clog2(N), width of index fields.
REQ-003 Parameter CNTW, default 16, width of grant statistics counter.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  N  request vector; bit i = requester i wants service.
REQ-007 stall  input  1  when high, suppresses all grants this cycle.
REQ-008 gnt  output  N  one-hot-or-zero grant vector, combinational from req, stall, rst and last pointer.
REQ-009 gnt_vld  output  1  high iff gnt != 0.
REQ-010 gnt_idx  output  logN  index of granted requester; 0 when gnt_vld low.
REQ-011 last_idx  output  logN  registered index of the most recently granted requester.
REQ-012 gnt_cnt  output  CNTW  registered saturating count of cycles with gnt_vld high.

Function
REQ-013 The block SHALL keep a last-granted pointer last_idx in range 0..N-1.
REQ-014 Search order SHALL be circular: last_idx+1, last_idx+2, ..., N-1, 0, ..., last_idx.
REQ-015 gnt SHALL select the first requester in search order with req high; same-cycle (zero-latency) grant.
REQ-016 gnt SHALL be $onehot0 in every cycle.
REQ-017 If req == 0, or stall high, or rst high, gnt SHALL be 0 and gnt_vld 0.
REQ-018 On a cycle with gnt_vld high, last_idx SHALL load gnt_idx at the next posedge.
REQ-019 On a cycle with gnt_vld low, last_idx SHALL hold its value.
REQ-020 Index wrap SHALL be computed modulo N, not modulo 2^logN; correct for non-power-of-2 N (e.g. last_idx=N-1 -> next search start 0).
REQ-021 A lone requester equal to last_idx SHALL be granted (it is last in search order, not excluded).
REQ-022 Requesters SHALL hold req high until granted and drop it the cycle after grant; the arbiter need not mask the just-granted requester if req remains high.
REQ-023 With stall low every cycle, a request held high SHALL be granted within N cycles of its rising edge (cycle of rise counts as 0).
REQ-024 If i is granted while j and k request, and j precedes k in search order from i, k SHALL NOT be granted before j.
REQ-025 gnt_cnt SHALL increment by 1 on each cycle with gnt_vld high and saturate at all-ones (no wrap).
REQ-026 stall SHALL not affect last_idx or gnt_cnt other than by suppressing grants.

Reset
REQ-027 While rst high: gnt = 0, gnt_vld = 0, gnt_idx = 0.
REQ-028 At the posedge with rst high: last_idx <= N-1 (requester 0 has top priority after reset), gnt_cnt <= 0.
REQ-029 Reset asserted mid-operation SHALL discard pointer history; no grant is issued in the reset cycle even if req != 0.
REQ-030 First cycle after rst deasserts SHALL arbitrate normally from last_idx = N-1.

Verification (N=10, CNTW=16)
REQ-031 Reset, then req=10'h3FF held, stall=0 -> gnt = 10'h001, 10'h002, ... 10'h200 on cycles 1..10, then 10'h001; gnt_cnt = 11 after 11 cycles.
REQ-032 last_idx=3, req bits 1 and 7 -> gnt=10'h080, gnt_idx=7; next cycle (bit 7 dropped) gnt=10'h002, last_idx then 1.
REQ-033 Wrap: last_idx=9, req bits 0 and 9 -> gnt=10'h001; last_idx=0; next cycle req bit 9 only -> gnt=10'h200.
REQ-034 stall=1 with req=10'h0F0, last_idx=2 -> gnt=0, gnt_vld=0, last_idx stays 2, gnt_cnt unchanged; stall=0 next cycle -> gnt=10'h010.
REQ-035 last_idx=5, gnt_cnt=37, req=10'h3FF, rst pulsed one cycle -> gnt=0 in rst cycle; afterwards last_idx=9, gnt_cnt=0, first grant 10'h001.
REQ-036 gnt_cnt preloaded via long run to 16'hFFFE, two more grant cycles -> gnt_cnt = 16'hFFFF and holds; random req/stall runs -> $onehot0(gnt) and REQ-023/REQ-024 never violated.
